imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
Registered instruction-decode stage that produces the operand-B select code and all sign-extended immediates consumed by the ALU operand-B mux.
- Accepts 32-bit RV32I instruction words over a valid/ready handshake.
- Decodes the opcode into imme_sel and extracts I/S/B/U/UJ immediates plus register addresses.
- Presents results through a 2-entry skid buffer, giving full throughput under backpressure.
- Sits between fetch and execute.

Parameters:
XLEN, 32, datapath width; only 32 is supported, and elaboration fails on any other value.
NOP_INSTR, 32'h0000_0013, value driven on o_instr while the output is empty or in reset.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction word valid
in_ready  out  1  stage can accept a word
in_instr  in  32  instruction word
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts the bundle
o_instr  out  32  pass-through instruction
imme_sel  out  3  operand-B select: 000 rs2, 001 I, 010 B, 011 S, 100 U, 101 UJ
i_imme  out  32  sign-extended I immediate
s_imme  out  32  sign-extended S immediate
b_imme  out  32  sign-extended B immediate (bit0=0)
uj_imme  out  32  sign-extended J immediate (bit0=0)
u_imme  out  32  {instr[31:12],12'b0}
rs1_addr, rs2_addr, rd_addr  out  5 each  register fields
illegal  out  1  unknown opcode in current bundle (see optional feature)

Behaviour:
- Reset (async assert, sync-deassert handled externally):
  - out_valid=0 and skid empty.
  - in_ready=1 from the first clock after deassert.
  - o_instr=NOP_INSTR; all immediates, addresses, imme_sel and illegal are 0.
- Opcode map (instr[6:0]):
  - 0110011 -> 000
  - 0010011, 0000011, 1100111 -> 001
  - 1100011 -> 010
  - 0100011 -> 011
  - 0110111, 0010111 -> 100
  - 1101111 -> 101
  - Any other opcode: imme_sel=000, illegal=1. Immediates are still extracted unconditionally.
- Transfers:
  - A transfer happens on valid&&ready at a rising edge.
  - Latency is 1 cycle: a word accepted in cycle N appears with out_valid=1 in cycle N+1 when the output register is empty or draining.
- Buffering: output register OR plus skid register SK; both hold a decoded bundle.
  - in_ready = !SK_valid, registered with no combinational path from out_ready.
  - Accept while OR is free or draining (out_ready=1): the decoded word loads OR.
  - Accept while OR is stalled (out_valid&&!out_ready): the decoded word loads SK; in_ready drops the next cycle.
  - OR drains while SK is valid: SK moves to OR, SK is cleared, in_ready returns to 1 the next cycle.
  - Simultaneous accept and drain with SK empty: the new word loads OR with no bubble.
- Ordering: strict FIFO; no drop and no duplication.
- Output stability: outputs hold stable while out_valid&&!out_ready.
- Reset mid-stream: both entries are discarded and nothing is replayed.

Optional Feature:
IMM_DEC_ILLEGAL_CHK_EN
- Defined:
  - illegal is computed per the opcode map.
  - An extra output illegal_seen (1 bit) goes high when an illegal bundle is accepted downstream, and stays high until reset.
- Undefined:
  - illegal is tied to 0 and illegal_seen is absent.
  - Unknown opcodes decode as 001 (I-type).

Decomposition:
- Package imm_dec_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_BRANCH, OP_STORE, OP_LUI, OP_AUIPC, OP_JAL);
  - imme_sel codes (SEL_RS2, SEL_I, SEL_B, SEL_S, SEL_U, SEL_UJ);
  - the decoded-bundle struct type.
- One combinational sub-module, imm_extract: instruction -> bundle (select code plus immediates).
- The top level holds the skid/handshake logic only.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1) -> imme_sel=001, i_imme=0xFFFFFFFF, rd_addr=1, out_valid one cycle after accept.
- 0x0020A423 (sw x2,8(x1)) -> imme_sel=011, s_imme=0x00000008, rs1_addr=1, rs2_addr=2.
- 0xFE000EE3 (beq x0,x0,-4) -> imme_sel=010, b_imme=0xFFFFFFFC. Then 0x001000EF (jal x1,+2048) -> imme_sel=101, uj_imme=0x00000800.
- 0x123452B7 (lui x5,0x12345) -> imme_sel=100, u_imme=0x12345000, rd_addr=5. Then 0x0000007F -> imme_sel=000, illegal=1 (with the macro defined), illegal_seen=1 after the bundle is accepted downstream.
- Stream 6 words back-to-back with out_ready low for cycles 2-4 -> in_ready=0 from cycle 3 until SK drains, all 6 arrive in order, outputs stable while stalled.
- Assert rst_n low with both entries full -> out_valid=0 and o_instr=0x00000013 immediately; after release, in_ready=1 and no stale bundle appears.

Source files
------------

// File: rtl/imm_dec_pkg.sv
// Shared definitions for the immediate decode stage: RV32I opcodes,
// operand-B select codes and the decoded bundle carried through the skid buffer.
package imm_dec_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] SEL_RS2 = 3'b000;
   localparam logic [2:0] SEL_I   = 3'b001;
   localparam logic [2:0] SEL_B   = 3'b010;
   localparam logic [2:0] SEL_S   = 3'b011;
   localparam logic [2:0] SEL_U   = 3'b100;
   localparam logic [2:0] SEL_UJ  = 3'b101;

   typedef struct packed {
      logic [31:0] instr;
      logic [2:0]  sel;
      logic [31:0] i_imm;
      logic [31:0] s_imm;
      logic [31:0] b_imm;
      logic [31:0] uj_imm;
      logic [31:0] u_imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        illegal;
   } imm_bundle_t;

endpackage

// File: rtl/imm_decode_stage_imm_extract.sv
// Combinational decode: instruction word -> select code, immediates and
// register fields. With IMM_DEC_ILLEGAL_CHK_EN defined, unknown opcodes select
// rs2 and flag illegal; otherwise they fall back to I-type and illegal is 0.
module imm_extract
   import imm_dec_pkg::*;
(
   input  logic [31:0] instr,
   output imm_bundle_t bundle
);

   logic [2:0] sel;
   logic       illegal;

   // Opcode to operand-B select map
   always_comb begin
      sel     = SEL_I;
      illegal = 1'b0;
      case (instr[6:0])
         OP_R:                       sel = SEL_RS2;
         OP_IMM, OP_LOAD, OP_JALR:   sel = SEL_I;
         OP_BRANCH:                  sel = SEL_B;
         OP_STORE:                   sel = SEL_S;
         OP_LUI, OP_AUIPC:           sel = SEL_U;
         OP_JAL:                     sel = SEL_UJ;
         default: begin
`ifdef IMM_DEC_ILLEGAL_CHK_EN
            sel     = SEL_RS2;
            illegal = 1'b1;
`else
            sel     = SEL_I;
            illegal = 1'b0;
`endif
         end
      endcase
   end

   // Field extraction is unconditional; the select code decides what is used
   always_comb begin
      bundle         = '0;
      bundle.instr   = instr;
      bundle.sel     = sel;
      bundle.illegal = illegal;
      bundle.i_imm   = {{20{instr[31]}}, instr[31:20]};
      bundle.s_imm   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      bundle.b_imm   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      bundle.uj_imm  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      bundle.u_imm   = {instr[31:12], 12'b0};
      bundle.rs1     = instr[19:15];
      bundle.rs2     = instr[24:20];
      bundle.rd      = instr[11:7];
   end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered decode stage with a 2-entry skid buffer (output register plus
// skid register). in_ready depends only on skid occupancy, so there is no
// combinational path from out_ready. Optional macro: IMM_DEC_ILLEGAL_CHK_EN
// enables illegal-opcode detection and the sticky illegal_seen output.
module imm_decode_stage
   import imm_dec_pkg::*;
#(
   parameter int          XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] o_instr,
   output logic [2:0]  imme_sel,
   output logic [31:0] i_imme,
   output logic [31:0] s_imme,
   output logic [31:0] b_imme,
   output logic [31:0] uj_imme,
   output logic [31:0] u_imme,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   output logic [4:0]  rd_addr,
`ifdef IMM_DEC_ILLEGAL_CHK_EN
   output logic        illegal_seen,
`endif
   output logic        illegal
);

   // Only a 32-bit datapath exists; refuse to elaborate anything else
   generate
      if (XLEN != 32) begin : g_bad_xlen
         $error("imm_decode_stage supports XLEN=32 only");
      end
   endgenerate

   imm_bundle_t dec_bundle;
   imm_bundle_t or_reg;
   imm_bundle_t sk_reg;
   logic        or_valid_reg;
   logic        sk_valid_reg;
   logic        accept;
   logic        drain;

   imm_extract u_extract (
      .instr  (in_instr),
      .bundle (dec_bundle)
   );

   assign in_ready = !sk_valid_reg;
   assign accept   = in_valid && in_ready;
   assign drain    = or_valid_reg && out_ready;

   // Skid buffer: OR refills from SK first, else from the decoder, keeping FIFO order
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         or_valid_reg <= 1'b0;
         sk_valid_reg <= 1'b0;
         or_reg       <= '0;
         sk_reg       <= '0;
      end else if (drain) begin
         if (sk_valid_reg) begin
            or_reg       <= sk_reg;
            sk_valid_reg <= 1'b0;
         end else if (accept) begin
            or_reg       <= dec_bundle;
         end else begin
            or_valid_reg <= 1'b0;
         end
      end else if (accept) begin
         if (!or_valid_reg) begin
            or_reg       <= dec_bundle;
            or_valid_reg <= 1'b1;
         end else begin
            sk_reg       <= dec_bundle;
            sk_valid_reg <= 1'b1;
         end
      end
   end

`ifdef IMM_DEC_ILLEGAL_CHK_EN
   logic illegal_seen_reg;

   // Sticky flag: set once an illegal bundle is taken downstream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_seen_reg <= 1'b0;
      end else if (drain && or_reg.illegal) begin
         illegal_seen_reg <= 1'b1;
      end
   end

   assign illegal_seen = illegal_seen_reg;
`endif

   // An empty output presents a NOP with all decoded fields cleared
   assign out_valid = or_valid_reg;
   assign o_instr   = or_valid_reg ? or_reg.instr   : NOP_INSTR;
   assign imme_sel  = or_valid_reg ? or_reg.sel     : 3'b000;
   assign i_imme    = or_valid_reg ? or_reg.i_imm   : 32'h0;
   assign s_imme    = or_valid_reg ? or_reg.s_imm   : 32'h0;
   assign b_imme    = or_valid_reg ? or_reg.b_imm   : 32'h0;
   assign uj_imme   = or_valid_reg ? or_reg.uj_imm  : 32'h0;
   assign u_imme    = or_valid_reg ? or_reg.u_imm   : 32'h0;
   assign rs1_addr  = or_valid_reg ? or_reg.rs1     : 5'd0;
   assign rs2_addr  = or_valid_reg ? or_reg.rs2     : 5'd0;
   assign rd_addr   = or_valid_reg ? or_reg.rd      : 5'd0;
   assign illegal   = or_valid_reg ? or_reg.illegal : 1'b0;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: reset state, per-format decode,
// back-to-back streaming under backpressure, and reset with both entries full.
module tb_imm_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] o_instr;
   logic [2:0]  imme_sel;
   logic [31:0] i_imme, s_imme, b_imme, uj_imme, u_imme;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        illegal;
`ifdef IMM_DEC_ILLEGAL_CHK_EN
   logic        illegal_seen;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   imm_decode_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o_instr   (o_instr),
      .imme_sel  (imme_sel),
      .i_imme    (i_imme),
      .s_imme    (s_imme),
      .b_imme    (b_imme),
      .uj_imme   (uj_imme),
      .u_imme    (u_imme),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rd_addr   (rd_addr),
`ifdef IMM_DEC_ILLEGAL_CHK_EN
      .illegal_seen (illegal_seen),
`endif
      .illegal   (illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one word for a single cycle; on return the bundle sits in OR
   task automatic send_word(input logic [31:0] w);
      in_instr = w;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      $display("send %h -> out_valid=%0b sel=%0d o_instr=%h", w, out_valid, imme_sel, o_instr);
   endtask

   logic [31:0] words [6];
   logic [31:0] held_instr;
   logic        prev_stall;
   int          idx, rx;
   logic        acc, drn;

   initial begin
      words[0] = 32'hFFF00093; words[1] = 32'h0020A423; words[2] = 32'hFE000EE3;
      words[3] = 32'h001000EF; words[4] = 32'h123452B7; words[5] = 32'h00000033;
      rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b1;
      #12;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_o_instr",   o_instr,   32'h00000013);
      chk("rst_imme_sel",  imme_sel,  3'b000);
      chk("rst_i_imme",    i_imme,    32'h0);
      chk("rst_rd_addr",   rd_addr,   5'd0);
      chk("rst_illegal",   illegal,   1'b0);
      @(negedge clk); rst_n = 1'b1;
      tick();
      chk("rst_in_ready",  in_ready,  1'b1);
`ifdef IMM_DEC_ILLEGAL_CHK_EN
      chk("rst_illegal_seen", illegal_seen, 1'b0);
`endif

      // addi x1,x0,-1
      send_word(32'hFFF00093);
      chk("addi_valid", out_valid, 1'b1);
      chk("addi_sel",   imme_sel,  3'b001);
      chk("addi_i",     i_imme,    32'hFFFFFFFF);
      chk("addi_rd",    rd_addr,   5'd1);
      chk("addi_instr", o_instr,   32'hFFF00093);
      tick();
      chk("addi_drained", out_valid, 1'b0);

      // sw x2,8(x1)
      send_word(32'h0020A423);
      chk("sw_sel", imme_sel, 3'b011);
      chk("sw_s",   s_imme,   32'h00000008);
      chk("sw_rs1", rs1_addr, 5'd1);
      chk("sw_rs2", rs2_addr, 5'd2);

      // beq x0,x0,-4 then jal x1,+2048
      send_word(32'hFE000EE3);
      chk("beq_sel", imme_sel, 3'b010);
      chk("beq_b",   b_imme,   32'hFFFFFFFC);
      send_word(32'h001000EF);
      chk("jal_sel", imme_sel, 3'b101);
      chk("jal_uj",  uj_imme,  32'h00000800);
      chk("jal_rd",  rd_addr,  5'd1);

      // lui x5,0x12345 then an unknown opcode
      send_word(32'h123452B7);
      chk("lui_sel", imme_sel, 3'b100);
      chk("lui_u",   u_imme,   32'h12345000);
      chk("lui_rd",  rd_addr,  5'd5);
      send_word(32'h0000007F);
`ifdef IMM_DEC_ILLEGAL_CHK_EN
      chk("bad_sel",     imme_sel, 3'b000);
      chk("bad_illegal", illegal,  1'b1);
      chk("bad_seen_pre", illegal_seen, 1'b0);
      tick();
      chk("bad_seen_post", illegal_seen, 1'b1);
`else
      chk("bad_sel",     imme_sel, 3'b001);
      chk("bad_illegal", illegal,  1'b0);
      tick();
`endif
      tick();

      // Six words back-to-back, out_ready low in cycles 2..4
      idx = 0; rx = 0; prev_stall = 1'b0; held_instr = 32'h0;
      for (int c = 1; c <= 12; c++) begin
         chk($sformatf("strm_in_ready_c%0d", c), in_ready, !(c >= 3 && c <= 5));
         chk($sformatf("strm_out_valid_c%0d", c), out_valid, (c >= 2 && c <= 10));
         if (prev_stall) chk($sformatf("strm_hold_c%0d", c), o_instr, held_instr);
         out_ready = !(c >= 2 && c <= 4);
         in_valid  = (idx < 6);
         in_instr  = (idx < 6) ? words[idx] : 32'h0;
         acc = in_valid && in_ready;
         drn = out_valid && out_ready;
         if (drn) begin
            chk($sformatf("strm_order_%0d", rx), o_instr, words[rx]);
            $display("stream c%0d: out %h", c, o_instr);
            rx++;
         end
         if (acc) idx++;
         prev_stall = out_valid && !out_ready;
         held_instr = o_instr;
         tick();
      end
      in_valid = 1'b0;
      chk("strm_count", rx, 6);

      // Fill both entries, then reset mid-stream
      out_ready = 1'b0;
      send_word(32'h00100093);
      send_word(32'h00200113);
      chk("full_in_ready", in_ready, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", out_valid, 1'b0);
      chk("mrst_o_instr",   o_instr,   32'h00000013);
      out_ready = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      tick();
      chk("mrst_in_ready", in_ready, 1'b1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("mrst_no_stale_%0d", k), out_valid, 1'b0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
